chunked_serial_adder: RTL

Multi-cycle, parametrised binary adder that computes `a + b + cin` over `WIDTH` bits, `CHUNK` bits per clock, with a rippled carry register between chunks. It is the sequential successor to the team's single-bit combinational full adder. It trades latency for area in wide datapaths, and degenerates to a bit-serial adder (`CHUNK=1`) or a registered single-cycle adder (`CHUNK=WIDTH`). A start/busy/done handshake lets a controller issue back-to-back operations.

---
 rtl/chunked_serial_adder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder
//   Multi-cycle adder computing a + b + cin over WIDTH bits, CHUNK bits per
//   clock, with the carry rippled between chunks through a register.
//   CHUNK=1 gives a bit-serial adder; CHUNK=WIDTH gives a registered
//   single-cycle adder.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request, sampled only while idle
//   a, b   in   WIDTH-bit operands, captured on the accepting edge
//   cin    in   carry-in, captured on the accepting edge
//   busy   out  high while an operation is in progress
//   done   out  one-cycle pulse when sum/cout/ovf are updated
//   sum    out  (a + b + cin) mod 2^WIDTH
//   cout   out  unsigned carry out of bit WIDTH-1
//   ovf    out  two's-complement overflow
module chunked_serial_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK:0]   chunk_res;
    logic [WIDTH-1:0] psum_next;

    // Operand registers shift right one chunk per cycle so the active chunk
    // is always the low slice, and each chunk result enters the partial sum
    // from the top; after NCHUNK cycles every chunk sits in its own slice.
    // This is equivalent to indexing slice cnt*CHUNK directly.
    always_comb begin
        chunk_res = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carry_q};
        psum_next = (psum_q >> CHUNK)
                  | (WIDTH'(chunk_res[CHUNK-1:0]) << (WIDTH - CHUNK));

        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        carry_d = carry_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    psum_d  = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                psum_d  = psum_next;
                carry_d = chunk_res[CHUNK];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    sum_d   = psum_next;
                    cout_d  = chunk_res[CHUNK];
                    // Carry into the MSB is recovered from the MSB sum bit.
                    ovf_d   = chunk_res[CHUNK]
                            ^ (a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_res[CHUNK-1]);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
